multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS datapath, sitting directly upstream of the ALU decoder. Decodes the 6-bit opcode of the instruction in the instruction register, steps through the fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects. The 2-bit ALUOp goes to the ALU decoder, which combines it with Funct to form ALUControl.

## Interface
- No parameters. Opcode, ALUOp and state encodings are fixed constants.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Op  in  6  instruction opcode (IR[31:26]), valid from DECODE onward.
- Zero  in  1  ALU zero flag, sampled combinationally in BEQ.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load enable.
- PCEn  out  1  PC load enable: PCWrite | (Branch & Zero).
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp  out  2  to ALU decoder: 00 = add, 01 = subtract, 10 = use Funct.
- RegDst  out  1  write register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  writeback data select: 0 = ALUOut, 1 = memory data.
- RegWrite  out  1  register file write enable.
- IllegalOp  out  1  one-cycle pulse in DECODE when Op is unsupported.

## Operation
- Moore FSM. All outputs are decoded from the current state only, except PCEn, which also uses Zero.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and the signals each asserts (every unlisted output is 0):
  - IDLE: nothing asserted. Always goes to FETCH next.
  - FETCH: IRWrite, PCWrite, ALUSrcB=01, ALUOp=00, PCSrc=00. Next state DECODE.
  - DECODE: ALUSrcB=11, ALUOp=00 (precomputes the branch target).
    - lw or sw go to MEMADR; R-type goes to EXECUTE; beq goes to BEQ; addi goes to ADDIEX; j goes to JUMP.
    - Any other opcode goes to FETCH with IllegalOp=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD: IorD=1. Next state MEMWB.
  - MEMWB: RegWrite, MemtoReg=1, RegDst=0. Next state FETCH.
  - MEMWR: IorD=1, MemWrite. Next state FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
  - ALUWB: RegWrite, RegDst=1, MemtoReg=0. Next state FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch, PCSrc=01. Next state FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
  - ADDIWB: RegWrite, RegDst=0, MemtoReg=0. Next state FETCH.
  - JUMP: PCWrite, PCSrc=10. Next state FETCH.
- The opcode is evaluated in DECODE and in MEMADR. Op must stay stable, because IRWrite is low outside FETCH.

## Timing
- Reset: with RST_N low, state = IDLE immediately (asynchronous) and every output is 0, including PCEn and IllegalOp. The first FETCH occurs one cycle after RST_N deasserts.
- Cycles per instruction, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- PCEn is high in FETCH, in JUMP, and in BEQ only when Zero=1. It is combinational with respect to Zero within the BEQ cycle.
- Reset asserted mid-instruction aborts the instruction at once. Any pending RegWrite, MemWrite or PCEn drops asynchronously, and no partial write may occur on the next edge.
- No handshake with memory: memory is single-cycle.

## Structure
- New shared include opcode.v (sits beside funct.v) holds the OP_* defines.
- The ALUOp defines (add 00, subtract 01, funct 10) move into a shared include used by both this block and the ALU decoder. This block must not define them locally.
- State encoding is a 4-bit localparam set private to the block.
- One natural sub-module: mc_output_decode, a combinational state-to-control-word map. The FSM register and next-state logic stay in multicycle_control.

## Test plan
- Reset with RST_N low mid-cycle: all outputs 0 immediately. After release: IDLE, then FETCH with IRWrite=1, PCEn=1, ALUSrcB=01.
- lw (Op=100011): states FETCH, DECODE, MEMADR, MEMRD, MEMWB. Exactly one RegWrite, with MemtoReg=1, in cycle 5. ALUOp=00 throughout.
- R-type (Op=000000): EXECUTE drives ALUOp=10. ALUWB drives RegWrite=1, RegDst=1. Next instruction fetch in cycle 5.
- beq (Op=000100), once with Zero=1 and once with Zero=0: BEQ drives ALUOp=01, PCSrc=01. PCEn=1 only for Zero=1. Back to FETCH after 3 cycles.
- Op=111111: IllegalOp=1 for exactly one cycle in DECODE, then FETCH. No RegWrite, MemWrite or extra PCEn.
- sw then reset pulse during MEMWR: MemWrite falls the instant RST_N goes low, and the state returns to IDLE.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
// Opcode and ALUOp encodings are shared with the ALU decoder.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output map: current FSM state to datapath control word.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = 2'b00;
      end
      // ALU computes PC+4 + (SignImm<<2) so BEQ can use ALUOut directly
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = 2'b01;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'b10;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// opcode-driven next-state logic and PC enable.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       IllegalOp
);

  state_t state, state_next;
  ctrl_t  ctrl;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    IllegalOp  = 1'b0;
    unique case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            state_next = S_FETCH;
            IllegalOp  = 1'b1;
          end
        endcase
      end
      // Op is held stable by the IR, so it is re-examined here to split lw/sw
      S_MEMADR:  state_next = (Op == OP_LW) ? S_MEMRD :
                              (Op == OP_SW) ? S_MEMWR : S_FETCH;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP:
                 state_next = S_FETCH;
      default:   state_next = S_IDLE;
    endcase
  end

  mc_output_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign IorD     = ctrl.iord;
  assign MemWrite = ctrl.mem_write;
  assign IRWrite  = ctrl.ir_write;
  assign PCEn     = ctrl.pc_write | (ctrl.branch & Zero);
  assign PCSrc    = ctrl.pc_src;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction cycle scripts
// push expected control words, a monitor compares them each cycle.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, IllegalOp;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;

  multicycle_control dut (
    .CLK(CLK), .RST_N(RST_N), .Op(Op), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp)
  );

  always #5 CLK = ~CLK;

  // {IorD,MemWrite,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALUOp,RegDst,MemtoReg,RegWrite,IllegalOp}
  logic [14:0] obs;
  assign obs = {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                RegDst, MemtoReg, RegWrite, IllegalOp};

  typedef enum {T_IDLE, T_FETCH, T_DECODE, T_DECODE_ILL, T_MEMADR, T_MEMRD, T_MEMWB,
                T_MEMWR, T_EXEC, T_ALUWB, T_BEQ, T_ADDIEX, T_ADDIWB, T_JUMP} step_e;

  logic [14:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [14:0] mk(logic iord, logic mw, logic irw, logic pcen,
                                     logic [1:0] pcsrc, logic srca, logic [1:0] srcb,
                                     logic [1:0] aop, logic rdst, logic m2r, logic rw,
                                     logic ill);
    return {iord, mw, irw, pcen, pcsrc, srca, srcb, aop, rdst, m2r, rw, ill};
  endfunction

  function automatic logic [14:0] expect_word(step_e s, logic z);
    case (s)
      T_FETCH:      return mk(0,0,1,1,2'b00,0,2'b01,2'b00,0,0,0,0);
      T_DECODE:     return mk(0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0);
      T_DECODE_ILL: return mk(0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,1);
      T_MEMADR:     return mk(0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
      T_MEMRD:      return mk(1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
      T_MEMWB:      return mk(0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,0);
      T_MEMWR:      return mk(1,1,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
      T_EXEC:       return mk(0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0);
      T_ALUWB:      return mk(0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0);
      T_BEQ:        return mk(0,0,0,z,2'b01,1,2'b00,2'b01,0,0,0,0);
      T_ADDIEX:     return mk(0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
      T_ADDIWB:     return mk(0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,0);
      T_JUMP:       return mk(0,0,0,1,2'b10,0,2'b00,2'b00,0,0,0,0);
      default:      return '0;
    endcase
  endfunction

  function automatic bit supported(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Instruction -> sequence of cycles starting from FETCH
  function automatic void script(logic [5:0] op, output step_e s[$]);
    s = {};
    s.push_back(T_FETCH);
    case (op)
      6'b100011: s = {s, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB};
      6'b101011: s = {s, T_DECODE, T_MEMADR, T_MEMWR};
      6'b000000: s = {s, T_DECODE, T_EXEC, T_ALUWB};
      6'b000100: s = {s, T_DECODE, T_BEQ};
      6'b001000: s = {s, T_DECODE, T_ADDIEX, T_ADDIWB};
      6'b000010: s = {s, T_DECODE, T_JUMP};
      default:   s.push_back(T_DECODE_ILL);
    endcase
  endfunction

  task automatic drive_step(step_e s, logic [5:0] op, int zmode);
    @(negedge CLK);
    Op   = op;
    Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
    exp_q.push_back(expect_word(s, Zero));
  endtask

  task automatic run_instr(logic [5:0] op, int zmode);
    step_e s[$];
    script(op, s);
    foreach (s[i]) drive_step(s[i], op, zmode);
  endtask

  task automatic check_now(string name, logic [14:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, obs, want, $time);
    end
  endtask

  // Reset pulse while in MEMWR; RST_N released at the next-but-one negedge.
  task automatic run_sw_abort();
    step_e s[$];
    script(6'b101011, s);
    foreach (s[i]) drive_step(s[i], 6'b101011, 2);
    #4 RST_N = 1'b0;
    #1 check_now("abort_async", '0);
    @(negedge CLK); exp_q.push_back('0);
    @(negedge CLK); RST_N = 1'b1; exp_q.push_back(expect_word(T_IDLE, 1'b0));
  endtask

  initial begin : monitor
    logic [14:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL cycle_word: got %b want %b at %0t", obs, e, $time);
        end
      end
    end
  end

  initial begin : driver
    logic [5:0] op;
    int sel;
    RST_N = 1'b0; Op = 6'b0; Zero = 1'b1;
    repeat (2) @(posedge CLK);
    #3 check_now("reset_zero", '0);
    @(negedge CLK);
    RST_N = 1'b1;
    Zero  = 1'b0;
    exp_q.push_back(expect_word(T_IDLE, 1'b0));

    run_instr(6'b100011, 2);
    run_instr(6'b000000, 2);
    run_instr(6'b000100, 1);
    run_instr(6'b000100, 0);
    run_instr(6'b111111, 1);
    run_instr(6'b001000, 2);
    run_instr(6'b000010, 2);
    run_sw_abort();
    run_instr(6'b101011, 2);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: begin
          op = 6'($urandom);
          while (supported(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, 2);
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge CLK);
    #4;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
